// File: rtl/mine_placer.sv
// Clears the mine-bitmap RAM, then places NUM_MINES mines at distinct LFSR-drawn cells.
// Draws that are out of range, equal to the safe cell, or already mined are discarded.
module mine_placer #(
    parameter int NUM_CELLS = 256,
    parameter int NUM_MINES = 40,
    parameter int DRAW_GAP  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] safe_cell,
    input  logic [7:0] rand_num,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       mem_wdata,
    input  logic       mem_rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] mines_placed
);

    localparam int               GAP_W       = $clog2(DRAW_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD  = GAP_W'(DRAW_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(1);
    localparam logic [7:0]       LAST_CELL   = 8'(NUM_CELLS - 1);
    localparam logic [8:0]       CELL_LIMIT  = 9'(NUM_CELLS);
    localparam logic [7:0]       MINE_TARGET = 8'(NUM_MINES);

    if (NUM_CELLS < 3 || NUM_CELLS > 256 || NUM_MINES < 1 || NUM_MINES > NUM_CELLS - 2 ||
        DRAW_GAP < 2) begin : g_param_check
        $error("mine_placer: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT, DRAW, READ, CHECK, WRITE, FIN} state_t;

    state_t           state;
    logic [7:0]       safe_q;
    logic [GAP_W-1:0] gap_cnt;

    // WAIT lasts DRAW_GAP-1 cycles so consecutive rejected samples are exactly DRAW_GAP apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            safe_q       <= '0;
            gap_cnt      <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mines_placed <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        safe_q       <= safe_cell;
                        mines_placed <= '0;
                        mem_addr     <= '0;
                        mem_we       <= 1'b1;
                        mem_wdata    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (mem_addr == LAST_CELL) begin
                        mem_we  <= 1'b0;
                        gap_cnt <= GAP_RELOAD;
                        state   <= WAIT;
                    end else begin
                        mem_addr <= mem_addr + 8'd1;
                    end
                end
                WAIT: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if ({1'b0, rand_num} >= CELL_LIMIT || rand_num == safe_q) begin
                        gap_cnt <= GAP_RELOAD;
                        state   <= WAIT;
                    end else begin
                        mem_addr <= rand_num;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (mem_rdata) begin
                        gap_cnt <= GAP_RELOAD;
                        state   <= WAIT;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_wdata <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    mem_wdata    <= 1'b0;
                    mines_placed <= mines_placed + 8'd1;
                    if (mines_placed + 8'd1 == MINE_TARGET) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        gap_cnt <= GAP_RELOAD;
                        state   <= WAIT;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer: four instances with different geometries, a sync RAM
// model each, and a cycle-level reference of when draws are sampled and what they place.
module tb_mine_placer;

    localparam int NOM = 0;
    localparam int ONE = 1;
    localparam int RNG = 2;
    localparam int DUP = 3;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start[4], mem_we[4], mem_wdata[4], mem_rdata[4], busy[4], done[4];
    logic [7:0] safe_cell[4], rand_num[4], mem_addr[4], mines_placed[4];
    logic       ram[4][256];

    int         cyc = 0;
    int         mw_cnt[4], clr_cnt[4], clr_bad[4], done_cnt[4], done_cyc[4];
    logic [7:0] clr_prev[4];
    logic [7:0] mw_addr[4][256];
    logic [7:0] stim_q[$];
    logic [7:0] exp_w[$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mine_placer #(
            .NUM_CELLS(g == 2 ? 100 : 256),
            .NUM_MINES(g == 0 ? 40 : (g == 3 ? 2 : 1)),
            .DRAW_GAP (GAP)
        ) dut (
            .clk(clk), .rst(rst), .start(start[g]), .safe_cell(safe_cell[g]),
            .rand_num(rand_num[g]), .mem_addr(mem_addr[g]), .mem_we(mem_we[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g]),
            .done(done[g]), .mines_placed(mines_placed[g])
        );

        always @(posedge clk) begin
            if (mem_we[g]) ram[g][mem_addr[g]] <= mem_wdata[g];
            mem_rdata[g] <= ram[g][mem_addr[g]];
        end

        // Clear writes must walk upward one cell at a time, restarting only at 0.
        always @(negedge clk) begin
            if (mem_we[g] && mem_wdata[g]) begin
                mw_addr[g][mw_cnt[g] % 256] = mem_addr[g];
                mw_cnt[g]++;
            end
            if (mem_we[g] && !mem_wdata[g]) begin
                if (mem_addr[g] != 8'd0 && mem_addr[g] != clr_prev[g] + 8'd1) clr_bad[g]++;
                clr_prev[g] = mem_addr[g];
                clr_cnt[g]++;
            end
            if (done[g]) begin
                done_cnt[g]++;
                done_cyc[g] = cyc;
            end
        end
    end

    // Drives one run and predicts it: the first sample lands NUM_CELLS+GAP edges after start;
    // a reject costs GAP, a duplicate GAP+2, a placement GAP+3; done shows 3 edges after the last.
    task automatic applyStimulus(input int k, input int ncells, input int nmines,
                                 input logic use_lfsr, input logic [7:0] seed,
                                 input logic [7:0] safe, input int poke_at,
                                 input logic [7:0] poke_safe,
                                 output int exp_done, output int busy_lo);
        bit         taken[256];
        int         placed, next_s, done_rel, e, t0;
        logic [7:0] v, lfsr;
        foreach (taken[i]) taken[i] = 1'b0;
        exp_w.delete();
        placed   = 0;
        done_rel = -1;
        busy_lo  = 0;
        lfsr     = seed;
        @(negedge clk);
        safe_cell[k] = safe;
        start[k]     = 1'b1;
        @(posedge clk);
        #1;
        t0           = cyc;
        start[k]     = 1'b0;
        safe_cell[k] = 8'($urandom);
        next_s       = ncells + GAP;
        e            = 0;
        while (1) begin
            if (done_rel < 0 || e <= done_rel) if (busy[k] !== 1'b1) busy_lo++;
            start[k] = (e == poke_at);
            if (e == poke_at) safe_cell[k] = poke_safe;
            if (use_lfsr) v = lfsr;
            else if (e + 1 == next_s && stim_q.size() > 0) v = stim_q.pop_front();
            else v = 8'($urandom);
            rand_num[k] = v;
            if (e + 1 == next_s && done_rel < 0) begin
                if (int'(v) >= ncells || v == safe) next_s += GAP;
                else if (taken[v]) next_s += GAP + 2;
                else begin
                    taken[v] = 1'b1;
                    exp_w.push_back(v);
                    placed++;
                    if (placed == nmines) done_rel = next_s + 3;
                    else next_s += GAP + 3;
                end
            end
            lfsr = {lfsr[6:0], ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3])};
            if (done_rel >= 0 && e >= done_rel + 2) break;
            if (e > 30000) break;
            @(posedge clk);
            #1;
            e++;
        end
        start[k] = 1'b0;
        checks++;
        if (done_rel < 0) begin
            errors++;
            $display("[TB] FAIL run_timeout: inst %0d model never completed", k);
        end
        exp_done = (done_rel < 0) ? -1 : t0 + done_rel;
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 4; k++) begin
            checks += 5;
            if (busy[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy[%0d]: got %b need 0", k, busy[k]); end
            if (done[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done[%0d]: got %b need 0", k, done[k]); end
            if (mem_we[k] !== 1'b0) begin errors++; $display("[TB] FAIL reset_we[%0d]: got %b need 0", k, mem_we[k]); end
            if (mem_addr[k] !== 8'd0) begin errors++; $display("[TB] FAIL reset_addr[%0d]: got %0d need 0", k, mem_addr[k]); end
            if (mines_placed[k] !== 8'd0) begin errors++; $display("[TB] FAIL reset_count[%0d]: got %0d need 0", k, mines_placed[k]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int m0, c0, b0, d0, exp_done, busy_lo, zeros, distinct, ones;
        bit seen[256];
        m0 = mw_cnt[NOM]; c0 = clr_cnt[NOM]; b0 = clr_bad[NOM]; d0 = done_cnt[NOM];
        applyStimulus(NOM, 256, 40, 1'b1, 8'hC5, 8'h00, -1, 8'h00, exp_done, busy_lo);
        checks += 7;
        if (clr_cnt[NOM] - c0 != 256) begin errors++; $display("[TB] FAIL nom_clear_count: got %0d need 256", clr_cnt[NOM] - c0); end
        if (clr_bad[NOM] != b0) begin errors++; $display("[TB] FAIL nom_clear_order: got %0d bad need 0", clr_bad[NOM] - b0); end
        if (mw_cnt[NOM] - m0 != 40) begin errors++; $display("[TB] FAIL nom_writes: got %0d need 40", mw_cnt[NOM] - m0); end
        if (done_cnt[NOM] - d0 != 1) begin errors++; $display("[TB] FAIL nom_done_pulses: got %0d need 1", done_cnt[NOM] - d0); end
        if (done_cyc[NOM] != exp_done) begin errors++; $display("[TB] FAIL nom_done_cycle: got %0d need %0d", done_cyc[NOM], exp_done); end
        if (mines_placed[NOM] !== 8'd40) begin errors++; $display("[TB] FAIL nom_count: got %0d need 40", mines_placed[NOM]); end
        if (busy_lo != 0 || busy[NOM] !== 1'b0) begin errors++; $display("[TB] FAIL nom_busy: got %0d low cycles, end %b need 0,0", busy_lo, busy[NOM]); end
        zeros = 0; distinct = 0; ones = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (exp_w[i]) begin
            checks++;
            if (mw_addr[NOM][(m0 + i) % 256] !== exp_w[i]) begin
                errors++;
                $display("[TB] FAIL nom_addr[%0d]: got %h need %h", i, mw_addr[NOM][(m0 + i) % 256], exp_w[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (mw_addr[NOM][(m0 + i) % 256] == 8'h00) zeros++;
            if (!seen[mw_addr[NOM][(m0 + i) % 256]]) distinct++;
            seen[mw_addr[NOM][(m0 + i) % 256]] = 1'b1;
        end
        for (int i = 0; i < 256; i++) if (ram[NOM][i] === 1'b1) ones++;
        checks += 3;
        if (zeros != 0) begin errors++; $display("[TB] FAIL nom_safe: got %0d writes to cell 0 need 0", zeros); end
        if (distinct != 40) begin errors++; $display("[TB] FAIL nom_distinct: got %0d need 40", distinct); end
        if (ones != 40) begin errors++; $display("[TB] FAIL nom_ram_ones: got %0d need 40", ones); end
    endtask

    task automatic test_reset_midclear();
        checks++;
        if (mines_placed[NOM] !== 8'd40) begin errors++; $display("[TB] FAIL hold_count: got %0d need 40", mines_placed[NOM]); end
        @(negedge clk);
        safe_cell[NOM] = 8'h00;
        start[NOM]     = 1'b1;
        @(posedge clk);
        #1;
        start[NOM] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checks += 3;
        if (mem_addr[NOM] !== 8'd100) begin errors++; $display("[TB] FAIL clear_addr: got %0d need 100", mem_addr[NOM]); end
        if (mem_we[NOM] !== 1'b1 || mem_wdata[NOM] !== 1'b0) begin errors++; $display("[TB] FAIL clear_we: got we=%b wdata=%b need 1,0", mem_we[NOM], mem_wdata[NOM]); end
        if (busy[NOM] !== 1'b1) begin errors++; $display("[TB] FAIL clear_busy: got %b need 1", busy[NOM]); end
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (busy[NOM] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b need 0", busy[NOM]); end
        if (mem_we[NOM] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_we: got %b need 0", mem_we[NOM]); end
        if (mines_placed[NOM] !== 8'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d need 0", mines_placed[NOM]); end
        if (mem_addr[NOM] !== 8'd0) begin errors++; $display("[TB] FAIL midrst_addr: got %0d need 0", mem_addr[NOM]); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_restart();
        int m0, c0, b0, exp_done, busy_lo;
        logic [7:0] seed, safe;
        seed = 8'($urandom_range(0, 254));
        safe = 8'($urandom_range(0, 254));
        m0 = mw_cnt[NOM]; c0 = clr_cnt[NOM]; b0 = clr_bad[NOM];
        applyStimulus(NOM, 256, 40, 1'b1, seed, safe, -1, 8'h00, exp_done, busy_lo);
        checks += 4;
        if (clr_cnt[NOM] - c0 != 256) begin errors++; $display("[TB] FAIL restart_clear_count: got %0d need 256", clr_cnt[NOM] - c0); end
        if (clr_bad[NOM] != b0) begin errors++; $display("[TB] FAIL restart_clear_order: got %0d bad need 0", clr_bad[NOM] - b0); end
        if (mw_cnt[NOM] - m0 != exp_w.size()) begin errors++; $display("[TB] FAIL restart_writes: got %0d need %0d", mw_cnt[NOM] - m0, exp_w.size()); end
        if (done_cyc[NOM] != exp_done) begin errors++; $display("[TB] FAIL restart_done_cycle: got %0d need %0d", done_cyc[NOM], exp_done); end
        foreach (exp_w[i]) begin
            checks++;
            if (mw_addr[NOM][(m0 + i) % 256] !== exp_w[i]) begin errors++; $display("[TB] FAIL restart_addr[%0d]: got %h need %h", i, mw_addr[NOM][(m0 + i) % 256], exp_w[i]); end
        end
    endtask

    task automatic test_safe_cell();
        int m0, d0, exp_done, busy_lo;
        m0 = mw_cnt[ONE]; d0 = done_cnt[ONE];
        stim_q = '{8'h2A, 8'h2A, 8'h2A, 8'h2B};
        applyStimulus(ONE, 256, 1, 1'b0, 8'h00, 8'h2A, -1, 8'h00, exp_done, busy_lo);
        checks += 5;
        if (mw_cnt[ONE] - m0 != 1) begin errors++; $display("[TB] FAIL safe_writes: got %0d need 1", mw_cnt[ONE] - m0); end
        if (mw_addr[ONE][m0 % 256] !== 8'h2B) begin errors++; $display("[TB] FAIL safe_addr: got %h need 2b", mw_addr[ONE][m0 % 256]); end
        if (done_cnt[ONE] - d0 != 1) begin errors++; $display("[TB] FAIL safe_done_pulses: got %0d need 1", done_cnt[ONE] - d0); end
        if (done_cyc[ONE] != exp_done) begin errors++; $display("[TB] FAIL safe_done_cycle: got %0d need %0d", done_cyc[ONE], exp_done); end
        if (ram[ONE][8'h2A] !== 1'b0) begin errors++; $display("[TB] FAIL safe_ram_2a: got %b need 0", ram[ONE][8'h2A]); end
    endtask

    task automatic test_range();
        int m0, exp_done, busy_lo;
        m0 = mw_cnt[RNG];
        stim_q = '{8'd150, 8'd100, 8'd99};
        applyStimulus(RNG, 100, 1, 1'b0, 8'h00, 8'h00, -1, 8'h00, exp_done, busy_lo);
        checks += 4;
        if (mw_cnt[RNG] - m0 != 1) begin errors++; $display("[TB] FAIL range_writes: got %0d need 1", mw_cnt[RNG] - m0); end
        if (mw_addr[RNG][m0 % 256] !== 8'd99) begin errors++; $display("[TB] FAIL range_addr: got %0d need 99", mw_addr[RNG][m0 % 256]); end
        if (done_cyc[RNG] != exp_done) begin errors++; $display("[TB] FAIL range_done_cycle: got %0d need %0d", done_cyc[RNG], exp_done); end
        if (mines_placed[RNG] !== 8'd1) begin errors++; $display("[TB] FAIL range_count: got %0d need 1", mines_placed[RNG]); end
    endtask

    task automatic test_duplicate();
        int m0, c0, exp_done, busy_lo;
        m0 = mw_cnt[DUP]; c0 = clr_cnt[DUP];
        stim_q = '{8'h10, 8'h10, 8'h11};
        applyStimulus(DUP, 256, 2, 1'b0, 8'h00, 8'h00, -1, 8'h00, exp_done, busy_lo);
        checks += 6;
        if (mw_cnt[DUP] - m0 != 2) begin errors++; $display("[TB] FAIL dup_writes: got %0d need 2", mw_cnt[DUP] - m0); end
        if (clr_cnt[DUP] - c0 != 256) begin errors++; $display("[TB] FAIL dup_zero_writes: got %0d need 256", clr_cnt[DUP] - c0); end
        if (mw_addr[DUP][m0 % 256] !== 8'h10) begin errors++; $display("[TB] FAIL dup_addr0: got %h need 10", mw_addr[DUP][m0 % 256]); end
        if (mw_addr[DUP][(m0 + 1) % 256] !== 8'h11) begin errors++; $display("[TB] FAIL dup_addr1: got %h need 11", mw_addr[DUP][(m0 + 1) % 256]); end
        if (done_cyc[DUP] != exp_done) begin errors++; $display("[TB] FAIL dup_done_cycle: got %0d need %0d", done_cyc[DUP], exp_done); end
        if (mines_placed[DUP] !== 8'd2) begin errors++; $display("[TB] FAIL dup_count: got %0d need 2", mines_placed[DUP]); end
    endtask

    task automatic test_start_busy();
        int m0, d0, exp_done, busy_lo;
        m0 = mw_cnt[ONE]; d0 = done_cnt[ONE];
        stim_q = '{8'h05, 8'h30, 8'h06};
        applyStimulus(ONE, 256, 1, 1'b0, 8'h00, 8'h30, 256 + 1, 8'h05, exp_done, busy_lo);
        repeat (20) @(posedge clk);
        #1;
        checks += 5;
        if (mw_cnt[ONE] - m0 != 1) begin errors++; $display("[TB] FAIL busy_start_writes: got %0d need 1", mw_cnt[ONE] - m0); end
        if (mw_addr[ONE][m0 % 256] !== 8'h05) begin errors++; $display("[TB] FAIL busy_start_addr: got %h need 05", mw_addr[ONE][m0 % 256]); end
        if (done_cnt[ONE] - d0 != 1) begin errors++; $display("[TB] FAIL busy_start_done_pulses: got %0d need 1", done_cnt[ONE] - d0); end
        if (done_cyc[ONE] != exp_done) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d need %0d", done_cyc[ONE], exp_done); end
        if (busy_lo != 0 || busy[ONE] !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_busy: got %0d low cycles, end %b need 0,0", busy_lo, busy[ONE]); end
    endtask

    task automatic test_back_to_back();
        int k, n, cells, m0, d0, exp_done, busy_lo;
        logic [7:0] safe;
        for (int r = 0; r < 6; r++) begin
            k     = (r % 2 == 0) ? RNG : DUP;
            cells = (k == RNG) ? 100 : 256;
            n     = (k == RNG) ? 1 : 2;
            safe  = 8'($urandom_range(0, cells - 1));
            m0 = mw_cnt[k]; d0 = done_cnt[k];
            stim_q.delete();
            applyStimulus(k, cells, n, 1'b0, 8'h00, safe, -1, 8'h00, exp_done, busy_lo);
            checks += 4;
            if (mw_cnt[k] - m0 != exp_w.size()) begin errors++; $display("[TB] FAIL b2b_writes[%0d]: got %0d need %0d", r, mw_cnt[k] - m0, exp_w.size()); end
            if (done_cnt[k] - d0 != 1) begin errors++; $display("[TB] FAIL b2b_done_pulses[%0d]: got %0d need 1", r, done_cnt[k] - d0); end
            if (done_cyc[k] != exp_done) begin errors++; $display("[TB] FAIL b2b_done_cycle[%0d]: got %0d need %0d", r, done_cyc[k], exp_done); end
            if (busy_lo != 0) begin errors++; $display("[TB] FAIL b2b_busy[%0d]: got %0d low cycles need 0", r, busy_lo); end
            foreach (exp_w[i]) begin
                checks++;
                if (mw_addr[k][(m0 + i) % 256] !== exp_w[i]) begin errors++; $display("[TB] FAIL b2b_addr[%0d.%0d]: got %h need %h", r, i, mw_addr[k][(m0 + i) % 256], exp_w[i]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            start[k]     = 1'b0;
            safe_cell[k] = 8'h00;
            rand_num[k]  = 8'h00;
        end
        #1 rst = 1'b1;
        test_reset();
        test_nominal();
        test_reset_midclear();
        test_restart();
        test_safe_cell();
        test_range();
        test_duplicate();
        test_start_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
